// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - single-port SRAM sequenced as a FIFO with round-robin wr/rd arbitration
// Optional almost_full/almost_empty outputs when SRAM_FIFO_ALMOST_EN is defined.
module sram_fifo_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int AF_LEVEL = 1020,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_row_sl,
  output logic              sram_chip_sl,
  inout  wire  [DATA_W-1:0] sram_data_io
`ifdef SRAM_FIFO_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_CAPTURE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W-1:0]   rptr;
  logic [DATA_W-1:0]   wdata;
  logic                drive;
  logic                last_grant;   // 1 = last grant went to the writer
  logic                wr_elig;
  logic                rd_elig;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_elig = wr_req & ~full;
  assign rd_elig = rd_req & ~empty;

  // drive is only set across the three write states, never while the SRAM is reading
  assign sram_data_io = drive ? wdata : {DATA_W{1'bz}};

`ifdef SRAM_FIFO_ALMOST_EN
  assign almost_full  = (count >= (ADDR_W+1)'(AF_LEVEL));
  assign almost_empty = (count <= (ADDR_W+1)'(AE_LEVEL));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wdata        <= '0;
      drive        <= 1'b0;
      last_grant   <= 1'b0;
      wr_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      sram_address <= '0;
      sram_row_sl  <= 1'b0;
      sram_chip_sl <= 1'b0;
    end else begin
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_elig && (!rd_elig || !last_grant)) begin
            wdata        <= wr_data;
            sram_address <= wptr;
            wr_ack       <= 1'b1;
            drive        <= 1'b1;
            last_grant   <= 1'b1;
            state        <= WR_SETUP;
          end else if (rd_elig) begin
            sram_address <= rptr;
            sram_chip_sl <= 1'b1;
            last_grant   <= 1'b0;
            state        <= RD_SETUP;
          end
        end
        WR_SETUP: begin
          sram_chip_sl <= 1'b1;
          sram_row_sl  <= 1'b1;
          state        <= WR_PULSE;
        end
        WR_PULSE: begin
          sram_chip_sl <= 1'b0;
          sram_row_sl  <= 1'b0;
          state        <= WR_HOLD;
        end
        WR_HOLD: begin
          drive <= 1'b0;
          wptr  <= wptr + 1'b1;
          count <= count + 1'b1;
          state <= IDLE;
        end
        RD_SETUP: state <= RD_CAPTURE;
        RD_CAPTURE: begin
          sram_chip_sl <= 1'b0;
          rd_data      <= sram_data_io;
          rptr         <= rptr + 1'b1;
          count        <= count - 1'b1;
          rd_valid     <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          drive        <= 1'b0;
          sram_chip_sl <= 1'b0;
          sram_row_sl  <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - scoreboard bench for sram_fifo_ctrl with a behavioural 1K x 8 SRAM
module tb_sram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic [10:0] count;
  logic [9:0]  sram_address;
  logic        sram_row_sl;
  logic        sram_chip_sl;
  wire  [7:0]  sram_data_io;
`ifdef SRAM_FIFO_ALMOST_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data[$];
  logic [9:0] exp_addr[$];
  int         m_wptr = 0;
  logic       prev_row = 1'b0;
  int         row_hi_cnt = 0;
  logic [7:0] mem [1024];

  always #5 clk = ~clk;

  sram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count),
    .sram_address(sram_address), .sram_row_sl(sram_row_sl),
    .sram_chip_sl(sram_chip_sl), .sram_data_io(sram_data_io)
`ifdef SRAM_FIFO_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  assign sram_data_io = (sram_chip_sl && !sram_row_sl) ? mem[sram_address] : 8'bz;

  always @(posedge clk)
    if (sram_chip_sl && sram_row_sl) mem[sram_address] <= sram_data_io;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_valid) begin
          if (exp_data.size() == 0) chk("rd_valid_unexpected", 1, 0);
          else chk("rd_data", rd_data, exp_data.pop_front());
        end
        if (sram_row_sl) begin
          row_hi_cnt++;
          chk("row_sl_one_cycle", prev_row, 0);
          chk("chip_sl_with_row_sl", sram_chip_sl, 1);
          if (exp_addr.size() == 0) chk("write_unexpected", 1, 0);
          else chk("write_address", sram_address, exp_addr.pop_front());
        end
      end
      prev_row = sram_row_sl;
    end
  end

  task automatic push_write(input logic [7:0] d);
    exp_data.push_back(d);
    exp_addr.push_back(10'(m_wptr));
    m_wptr = (m_wptr + 1) % 1024;
  endtask

  task automatic do_write(input logic [7:0] d, input bit chk_lat);
    int n = 0;
    push_write(d);
    wr_data = d;
    wr_req  = 1'b1;
    do begin @(negedge clk); n++; end while (!wr_ack && n < 200);
    if (chk_lat) chk("wr_ack_latency", n, 1);
    else if (!wr_ack) chk("wr_ack_timeout", 0, 1);
    wr_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_read(input bit chk_lat);
    int n = 0;
    rd_req = 1'b1;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 200);
    if (chk_lat) chk("rd_valid_latency", n, 3);
    else if (!rd_valid) chk("rd_valid_timeout", 0, 1);
    rd_req = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    int gseq[4];
    int cseq[4];
    int ng, nc, nw, nr;
    logic [10:0] pc;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_wr_ack", wr_ack, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_chip_sl", sram_chip_sl, 0);
    chk("reset_row_sl", sram_row_sl, 0);
    chk("reset_address", sram_address, 0);

    // single write, then read it back
    do_write(8'hA5, 1);
    chk("t1_row_sl_cycles", row_hi_cnt, 1);
    chk("t1_count", count, 1);
    chk("t1_empty", empty, 0);
    do_read(1);

    // ordered writes then reads
    do_write(8'h11, 1);
    do_write(8'h22, 1);
    do_write(8'h33, 1);
    chk("t2_count3", count, 3);
    do_read(1);
    do_read(1);
    do_read(1);
    chk("t2_empty", empty, 1);
    chk("t2_count0", count, 0);

    // async reset in the middle of a write
    wr_data = 8'h5A;
    wr_req  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!sram_row_sl && n < 10);
    chk("t5_reached_pulse", sram_row_sl, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_chip_sl_async", sram_chip_sl, 0);
    chk("t5_row_sl_async", sram_row_sl, 0);
    chk("t5_count", count, 0);
    wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_wptr = 0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (wr_ack) seen = 1'b1; end
    chk("t5_no_ack_after_reset", seen, 0);
    chk("t5_count_after", count, 0);
    chk("t5_empty_after", empty, 1);

    // fill completely, hold a write against full, then wrap
    for (int i = 0; i < 1024; i++) do_write(i[7:0], 0);
    chk("t3_full", full, 1);
    chk("t3_count", count, 1024);
    push_write(8'hEE);
    wr_data = 8'hEE;
    wr_req  = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (wr_ack) seen = 1'b1; end
    chk("t3_no_ack_when_full", seen, 0);
    chk("t3_count_held", count, 1024);
    do_read(1);
    chk("t3_count_after_read", count, 1023);
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_ack && n < 20);
    chk("t3_ack_after_read", wr_ack, 1);
    wr_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_full_again", full, 1);

    // drain down to 5 entries
    for (int i = 0; i < 1019; i++) do_read(0);
    chk("t4_start_count", count, 5);

    // contention: both requests held
    ng = 0; nc = 0; nw = 0; nr = 0;
    pc = count;
    push_write(8'hC1);
    wr_data = 8'hC1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int k = 0; k < 100 && nr < 2; k++) begin
      @(negedge clk);
      if (count != pc) begin
        if (nc < 4) cseq[nc] = int'(count);
        nc++;
        pc = count;
      end
      if (wr_ack) begin
        if (ng < 4) gseq[ng] = 1;
        ng++; nw++;
        if (nw >= 2) wr_req = 1'b0;
        else begin push_write(8'hC2); wr_data = 8'hC2; end
      end
      if (rd_valid) begin
        if (ng < 4) gseq[ng] = 0;
        ng++; nr++;
        if (nr >= 2) rd_req = 1'b0;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("t4_grant_count", ng, 4);
    chk("t4_count_changes", nc, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t4_grant_order", (k < ng) ? gseq[k] : 32'hFF, (k % 2 == 0) ? 1 : 0);
      chk("t4_count_seq", (k < nc) ? cseq[k] : 32'hFFFF, (k % 2 == 0) ? 6 : 5);
    end
    repeat (3) @(negedge clk);

`ifdef SRAM_FIFO_ALMOST_EN
    chk("t6_ae_at5", almost_empty, 0);
    do_read(0);
    chk("t6_ae_at4", almost_empty, 1);
    chk("t6_af_at4", almost_full, 0);
    for (int i = 0; i < 1015; i++) do_write(8'h77, 0);
    chk("t6_count1019", count, 1019);
    chk("t6_af_at1019", almost_full, 0);
    do_write(8'h78, 0);
    chk("t6_af_at1020", almost_full, 1);
    chk("t6_ae_at1020", almost_empty, 0);
`endif

    repeat (5) @(negedge clk);
    chk("all_writes_reached_sram", exp_addr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
